interval_capture: RTL and testbench



---
 rtl/interval_capture.sv | 103 ++++++++++
 tb/tb_interval_capture.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/interval_capture.sv
// Interval capture: counts CLK cycles from an ARM strobe to the next STOP,
// with saturating timeout, and offers the result over a VALID/READY handshake.
module interval_capture #(
  parameter int unsigned CNT_W     = 21,
  parameter int unsigned MAX_COUNT = 2097151
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             ARM,
  input  logic             STOP,
  input  logic             READY,
  output logic [CNT_W-1:0] RESULT,
  output logic             TIMEOUT,
  output logic             VALID,
  output logic             BUSY
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_MEASURE = 2'd1;
  localparam logic [1:0] S_HOLD    = 2'd2;

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_COUNT);

  logic [1:0]       state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [CNT_W-1:0] result_q,  result_d;
  logic             timeout_q, timeout_d;
  logic             valid_q,   valid_d;
  logic             busy_q,    busy_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    timeout_d = timeout_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    case (state_q)
      S_IDLE: begin
        if (ARM) begin
          state_d = S_MEASURE;
          cnt_d   = CNT_W'(1);
          busy_d  = 1'b1;
        end
      end
      S_MEASURE: begin
        // STOP outranks both timeout and re-arm on the same edge.
        if (STOP) begin
          result_d  = cnt_q;
          timeout_d = 1'b0;
          valid_d   = 1'b1;
          busy_d    = 1'b0;
          state_d   = S_HOLD;
        end else if (cnt_q == MAX_C) begin
          result_d  = MAX_C;
          timeout_d = 1'b1;
          valid_d   = 1'b1;
          busy_d    = 1'b0;
          state_d   = S_HOLD;
        end else if (ARM) begin
          cnt_d = CNT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (valid_q && READY) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      result_q  <= '0;
      timeout_q <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      timeout_q <= timeout_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  assign RESULT  = result_q;
  assign TIMEOUT = timeout_q;
  assign VALID   = valid_q;
  assign BUSY    = busy_q;

endmodule

// File: tb/tb_interval_capture.sv
// Scoreboard bench for interval_capture with MAX_COUNT=10.
module tb_interval_capture;

  localparam int unsigned CNT_W = 21;
  localparam int unsigned MAXC  = 10;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic             ARM = 1'b0;
  logic             STOP = 1'b0;
  logic             READY = 1'b1;
  logic [CNT_W-1:0] RESULT;
  logic             TIMEOUT;
  logic             VALID;
  logic             BUSY;

  typedef struct {
    logic [CNT_W-1:0] result;
    logic             timeout;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  logic seen = 1'b0;

  interval_capture #(.CNT_W(CNT_W), .MAX_COUNT(MAXC)) dut (
    .CLK(CLK), .RST_N(RST_N), .ARM(ARM), .STOP(STOP), .READY(READY),
    .RESULT(RESULT), .TIMEOUT(TIMEOUT), .VALID(VALID), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int unsigned r, input logic t);
    exp_t e;
    e.result  = CNT_W'(r);
    e.timeout = t;
    exp_q.push_back(e);
  endtask

  // Pops one expectation per rising VALID and compares the held result.
  always @(negedge CLK) begin
    if (VALID && !seen) begin
      seen = 1'b1;
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'(VALID), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result", 32'(RESULT), 32'(e.result));
        chk("timeout", 32'(TIMEOUT), 32'(e.timeout));
        chk("busy_at_valid", 32'(BUSY), 32'd0);
      end
    end else if (!VALID) begin
      seen = 1'b0;
    end
  end

  // ARM sampled at edge t0, STOP sampled at edge t0+n.
  task automatic arm_stop(input int unsigned n, input logic stop_with_arm);
    @(negedge CLK);
    ARM  = 1'b1;
    STOP = stop_with_arm;
    @(negedge CLK);
    ARM  = 1'b0;
    STOP = 1'b0;
    chk("busy_after_arm", 32'(BUSY), 32'd1);
    chk("valid_after_arm", 32'(VALID), 32'd0);
    repeat (n - 1) @(negedge CLK);
    STOP = 1'b1;
    push_exp(n, 1'b0);
    @(negedge CLK);
    STOP = 1'b0;
  endtask

  task automatic wait_released();
    for (int i = 0; i < 20; i++) begin
      if (!VALID) break;
      @(negedge CLK);
    end
    chk("handshake", 32'(VALID), 32'd0);
    chk("busy_idle", 32'(BUSY), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    chk("rst_result", 32'(RESULT), 32'd0);
    chk("rst_timeout", 32'(TIMEOUT), 32'd0);
    chk("rst_valid", 32'(VALID), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    RST_N = 1'b1;

    // Basic interval, READY held high: VALID lasts exactly one cycle.
    arm_stop(7, 1'b0);
    chk("basic_valid", 32'(VALID), 32'd1);
    @(negedge CLK);
    chk("basic_valid_drop", 32'(VALID), 32'd0);
    wait_released();

    arm_stop(1, 1'b0);
    wait_released();

    // STOP coinciding with counter==MAX wins over timeout.
    arm_stop(MAXC, 1'b0);
    wait_released();

    // STOP together with ARM in IDLE is ignored.
    arm_stop(3, 1'b1);
    wait_released();

    // Re-arm after 4 edges, STOP 3 edges after the second ARM; hold with READY low.
    READY = 1'b0;
    @(negedge CLK);
    ARM = 1'b1;
    @(negedge CLK);
    ARM = 1'b0;
    repeat (3) @(negedge CLK);
    ARM = 1'b1;
    @(negedge CLK);
    ARM = 1'b0;
    chk("rearm_busy", 32'(BUSY), 32'd1);
    repeat (2) @(negedge CLK);
    STOP = 1'b1;
    push_exp(3, 1'b0);
    @(negedge CLK);
    STOP = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ARM  = i[0];
      STOP = ~i[0];
      @(negedge CLK);
      chk("hold_valid", 32'(VALID), 32'd1);
      chk("hold_result", 32'(RESULT), 32'd3);
      chk("hold_busy", 32'(BUSY), 32'd0);
    end
    ARM   = 1'b0;
    STOP  = 1'b0;
    READY = 1'b1;
    @(negedge CLK);
    chk("hold_release", 32'(VALID), 32'd0);
    wait_released();

    // Timeout with no STOP.
    @(negedge CLK);
    ARM = 1'b1;
    push_exp(MAXC, 1'b1);
    @(negedge CLK);
    ARM = 1'b0;
    for (int i = 1; i < int'(MAXC); i++) begin
      chk("to_pending_valid", 32'(VALID), 32'd0);
      chk("to_pending_busy", 32'(BUSY), 32'd1);
      @(negedge CLK);
    end
    for (int i = 0; i < 5; i++) begin
      if (VALID) break;
      @(negedge CLK);
    end
    chk("to_valid", 32'(VALID), 32'd1);
    chk("to_busy", 32'(BUSY), 32'd0);
    wait_released();
    chk("to_retained_result", 32'(RESULT), 32'(MAXC));
    chk("to_retained_timeout", 32'(TIMEOUT), 32'd1);

    // Asynchronous reset mid-count clears everything before the next edge.
    @(negedge CLK);
    ARM = 1'b1;
    @(negedge CLK);
    ARM = 1'b0;
    repeat (3) @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    chk("arst_busy", 32'(BUSY), 32'd0);
    chk("arst_valid", 32'(VALID), 32'd0);
    chk("arst_result", 32'(RESULT), 32'd0);
    chk("arst_timeout", 32'(TIMEOUT), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    arm_stop(2, 1'b0);
    wait_released();

    repeat (2) @(negedge CLK);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
